// File: rtl/sub_shift_stage_if.sv
// Handshake bundle between the round controller and sub_shift_stage.
//   valid_i/ready_o/state_i : input block transfer into the stage
//   valid_o/ready_i/state_o : result transfer towards mixcolumn
// master = block producer/consumer side, slave = the stage itself.
interface sub_shift_stage_if;
    localparam int unsigned STATE_W = 128;

    logic               valid_i;
    logic               ready_o;
    logic [STATE_W-1:0] state_i;
    logic               valid_o;
    logic               ready_i;
    logic [STATE_W-1:0] state_o;

    modport master (
        output valid_i,
        output state_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  state_o
    );

    modport slave (
        input  valid_i,
        input  state_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output state_o
    );
endinterface

// File: rtl/sub_shift_stage.sv
// Iterative AES SubBytes + ShiftRows stage, one column (4 bytes) per cycle.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - sub_shift_stage_if.slave: valid_i/ready_o/state_i in,
//            valid_o/ready_i/state_o out (state_o feeds mixcolumn_i)
// Byte k of a state is bits [127-8k -: 8], k = 4*col + row.
module sub_shift_stage (
    input  logic              clk_i,
    input  logic              rst_ni,
    sub_shift_stage_if.slave  bus
);
    localparam int unsigned STATE_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned N_ROWS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [1:0]         col_q;
    logic [STATE_W-1:0] in_q;
    logic [STATE_W-1:0] out_q;
    logic               ready_q;
    logic               valid_q;
    logic [STATE_W-1:0] out_next_c;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: inverse as x^254 (= x^2 * x^4 * ... * x^128, maps 0 to 0), then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    // Four S-boxes on column col_q, each result dropped at its ShiftRows slot:
    // row r of source column c lands in destination column (c - r) mod 4.
    always_comb begin
        out_next_c = out_q;
        for (int r = 0; r < int'(N_ROWS); r++) begin
            logic [1:0] dst_col;
            dst_col = col_q - 2'(r);
            out_next_c[BYTE_W*(15 - (4*int'(dst_col) + r)) +: BYTE_W] =
                sbox(in_q[BYTE_W*(15 - (4*int'(col_q) + r)) +: BYTE_W]);
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            in_q    <= '0;
            out_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        in_q    <= bus.state_i;
                        col_q   <= 2'd0;
                        state_q <= ST_SUB;
                        ready_q <= 1'b0;
                    end
                end
                ST_SUB: begin
                    out_q <= out_next_c;
                    col_q <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    col_q   <= 2'd0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.state_o = out_q;

endmodule

// File: tb/tb_sub_shift_stage.sv
// Self-checking bench for sub_shift_stage: vector table, handshake corner
// sequences and randomized blocks against a table-based AES reference.
module tb_sub_shift_stage;
    logic clk;
    logic rst_n;

    sub_shift_stage_if bus ();

    sub_shift_stage dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [2047:0] sbox_flat;
    logic [7:0]    sbox_tab [256];

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int k);
        return s[127-8*k -: 8];
    endfunction

    // SubBytes then ShiftRows: out[c][r] = S(in[(c+r)%4][r])
    function automatic logic [127:0] ref_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox_tab[get_byte(s, 4*((c+r)%4)+r)];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] ref_mixcol(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
            o[127-8*(4*c+3) -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer a block, wait for acceptance, then count edges until valid_o
    task automatic send_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
        int n;
        n = 0;
        while (!bus.ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        bus.state_i = din;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = bus.state_o;
    endtask

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] got;
    logic [127:0] held;
    logic [127:0] bb_in [3];
    logic [127:0] bb_out [$];
    int           acc_t [3];
    int           lat;
    int           idx;
    int           cyc;
    int           k;
    logic         acc;
    logic [127:0] rnd;

    initial begin
        total = 0;
        bad   = 0;
        sbox_flat = SBOX_FLAT;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_flat[2047-8*i -: 8];

        vecs[0] = '{"fips_round1", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                    128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[1] = '{"all_zero", 128'h0, {16{8'h63}}};
        vecs[2] = '{"all_52", {16{8'h52}}, 128'h0};

        bus.valid_i = 1'b0;
        bus.state_i = '0;
        bus.ready_i = 1'b1;
        rst_n = 1'b0;
        #23;
        check("reset_ready", 128'(bus.ready_o), 128'(1'b1));
        check("reset_valid", 128'(bus.valid_o), 128'(1'b0));
        check("reset_state", bus.state_o, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven known vectors
        for (int i = 0; i < 3; i++) begin
            send_block(vecs[i].din, got, lat);
            check({vecs[i].name, "_out"}, got, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 128'(lat), 128'(4));
            if (i == 0) check("fips_mixcol", ref_mixcol(got), 128'h046681e5e0cb199a48f8d37a2806264c);
            @(posedge clk); #1;
            check({vecs[i].name, "_ready_after"}, 128'(bus.ready_o), 128'(1'b1));
        end

        // Backpressure: hold ready_i low, pulse valid_i with junk
        bus.ready_i = 1'b0;
        send_block(128'h00112233445566778899aabbccddeeff, held, lat);
        check("bp_first_out", held, ref_sub_shift(128'h00112233445566778899aabbccddeeff));
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = i[0];
            bus.state_i = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("bp_state_hold", bus.state_o, held);
            check("bp_valid_hold", 128'(bus.valid_o), 128'(1'b1));
            check("bp_ready_low", 128'(bus.ready_o), 128'(1'b0));
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_rise", 128'(bus.ready_o), 128'(1'b1));
        check("bp_valid_fall", 128'(bus.valid_o), 128'(1'b0));

        // Back-to-back with valid_i held high
        bb_in[0] = 128'h3243f6a8885a308d313198a2e0370734;
        bb_in[1] = 128'hffeeddccbbaa99887766554433221100;
        bb_in[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        idx = 0;
        cyc = 0;
        bus.state_i = bb_in[0];
        bus.valid_i = 1'b1;
        for (int t = 0; t < 40; t++) begin
            acc = bus.ready_o && bus.valid_i;
            if (bus.valid_o && bus.ready_i) bb_out.push_back(bus.state_o);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (idx < 3) acc_t[idx] = cyc;
                idx++;
                if (idx < 3) bus.state_i = bb_in[idx];
                else bus.valid_i = 1'b0;
            end
        end
        check("b2b_accept_count", 128'(idx), 128'(3));
        check("b2b_gap_01", 128'(acc_t[1] - acc_t[0]), 128'(6));
        check("b2b_gap_12", 128'(acc_t[2] - acc_t[1]), 128'(6));
        check("b2b_out_count", 128'(bb_out.size()), 128'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < bb_out.size()) check("b2b_out", bb_out[i], ref_sub_shift(bb_in[i]));
        end

        // Asynchronous reset at E2 of a SUB sequence
        bus.state_i = 128'hdeadbeefcafebabe0123456789abcdef;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(bus.valid_o), 128'(1'b0));
        check("mid_rst_ready", 128'(bus.ready_o), 128'(1'b1));
        check("mid_rst_state", bus.state_o, 128'h0);
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(128'h6bc1bee22e409f96e93d7e117393172a, got, lat);
        check("post_rst_out", got, ref_sub_shift(128'h6bc1bee22e409f96e93d7e117393172a));
        check("post_rst_latency", 128'(lat), 128'(4));
        @(posedge clk); #1;

        // Randomized blocks with random output backpressure
        for (int n = 0; n < 1000; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            bus.ready_i = 1'b0;
            send_block(rnd, got, lat);
            k = $urandom_range(0, 3);
            for (int w = 0; w < k; w++) begin
                @(posedge clk); #1;
            end
            check("rnd_out", bus.state_o, ref_sub_shift(rnd));
            if (lat != 4) check("rnd_latency", 128'(lat), 128'(4));
            bus.ready_i = 1'b1;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sub_shift_stage.md
# sub_shift_stage

Iterative AES SubBytes + ShiftRows stage that sits directly upstream of `mixcolumn` in the AES-256-CTR round datapath.
- Accepts a 128-bit state over a valid/ready handshake.
- Substitutes one column (4 bytes) per cycle through four in-block S-box instances.
- Writes each substituted byte straight to its ShiftRows position.
- Presents the result on `state_o`, which the round logic drives into `mixcolumn_i`.

## Interface
Parameters: none.

Ports:
- `clk_i`  input  1  clock; all state updates on its rising edge.
- `rst_ni`  input  1  reset, asynchronous assert, active-low.
- `valid_i`  input  1  `state_i` is valid this cycle.
- `ready_o`  output  1  stage can accept a new state.
- `state_i`  input  128  input state; byte k = bits [127-8k -: 8], k = 4c + r (column-major, FIPS-197 order).
- `valid_o`  output  1  `state_o` holds a completed result.
- `ready_i`  input  1  downstream accepts `state_o`.
- `state_o`  output  128  SubBytes(ShiftRows-mapped) result, same byte ordering as `state_i`.

## Operation
- States:
  - IDLE: `ready_o` = 1.
  - SUB: 2-bit column counter `col`.
  - DONE: `valid_o` = 1.
- IDLE:
  - On an edge with `valid_i` && `ready_o`, capture `state_i` into the input register.
  - Set `col` = 0 and go to SUB.
  - With `valid_i` low, stay in IDLE.
- SUB, each edge:
  - Apply the S-box to input bytes 4·`col`+r, r = 0..3.
  - Write S(in[4·`col`+r]) to output byte 4·((`col` − r) mod 4) + r, which places it at its ShiftRows position (row r rotated left by r).
  - Increment `col`.
  - On the edge where `col` = 3, go to DONE; `col` wraps to 0.
- DONE:
  - Hold `state_o` and `valid_o`.
  - On an edge with `ready_i` high, go to IDLE.
  - While `ready_i` is low, `state_o` stays bit-stable.
- Resulting mapping: `state_o` byte 4c+r = S(`state_i` byte 4((c+r) mod 4)+r).
- S-box:
  - Forward AES S-box (GF(2^8) inverse with polynomial 0x11B, then the affine transform with constant 0x63).
  - Implemented inside this block as a function or LUT and instantiated 4×.
  - No inverse S-box.
- `ready_o` is 1 only in IDLE. `valid_o` is 1 only in DONE. No acceptance is possible while busy, so no simultaneous accept and emit.
- `valid_i` and `state_i` are ignored outside IDLE. Input captured at acceptance is immune to later `state_i` changes.
- Reset (`rst_ni` low, at any time including mid-SUB or in DONE):
  - State → IDLE, `col` → 0, input and output registers → 0.
  - `ready_o` → 1, `valid_o` → 0, `state_o` → 128'h0.
  - Any in-flight block is discarded.

## Timing
- Acceptance edge E0 → SUB edges E1..E4 → `valid_o` high from just after E4.
- Latency is 4 cycles from the acceptance edge to `valid_o`.
- If `ready_i` is already high, the output handshake completes at E5. `ready_o` rises after E5, and the next block can be accepted at E6.
- Maximum throughput: one block per 6 cycles.
- `ready_o` and `valid_o` are decoded directly from the state register (no combinational path from `valid_i` or `ready_i`).
- `state_o` is a registered output. Partially written bytes are visible during SUB but are qualified by `valid_o` = 0.
- No combinational input-to-output paths.

## Test plan
- FIPS-197 App. B round 1:
  - Stimulus: `state_i` = 128'h193de3bea0f4e22b9ac68d2ae9f84808, `ready_i` = 1.
  - Required: `state_o` = 128'hd4bf5d30e0b452aeb84111f11e2798e5, with `valid_o` rising exactly 4 cycles after acceptance.
  - Additionally, feed this output to `mixcolumn`; it must produce 128'h046681e5e0cb199a48f8d37a2806264c.
- Constant inputs:
  - `state_i` = 128'h0 → `state_o` = 128'h6363…63 (all bytes 0x63).
  - `state_i` = all 0x52 bytes → `state_o` = 128'h0.
- Backpressure:
  - Hold `ready_i` = 0 for 10 cycles after `valid_o` rises.
  - `state_o` and `valid_o` stay stable, and `ready_o` stays 0.
  - `valid_i` pulsed with new data during this time is ignored.
  - Release `ready_i`; `ready_o` must rise the next cycle.
- Back-to-back:
  - Keep `valid_i` high with three distinct vectors, presenting the next vector after each acceptance.
  - Each vector must be accepted exactly once, 6 cycles apart, with correct outputs in order.
- Reset mid-operation:
  - Deassert `rst_ni` asynchronously at E2 of a SUB sequence.
  - Immediately: `valid_o` = 0, `ready_o` = 1, `state_o` = 0.
  - After release, a fresh block completes correctly with 4-cycle latency.
- Random:
  - 1000 random `state_i` values with random `ready_i` backpressure.
  - Compare against a reference model of SubBytes followed by ShiftRows.
